// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the reader and the display-side encoder.
//   - STABLE_CYCLES_DEFAULT : default debounce length in synchronized samples
//   - SEG_*                 : segment patterns, bit0 = a ... bit6 = g, active high
//   - rd_state_t            : byte-assembly FSM states
//   - hex_to_seg()          : nibble -> segment pattern for the encoder side
package seg7_pkg;

  localparam int STABLE_CYCLES_DEFAULT = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_GOT_LO = 2'd1,
    ST_GOT_HI = 2'd2
  } rd_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern decoder.
//   pattern : segments g..a, active high
//   valid   : pattern is one of the sixteen hex glyphs
//   blank   : pattern is all segments off
//   nibble  : decoded hex value (0 when not valid)
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic       blank,
  output logic [3:0] nibble
);

  // Map a glyph to its hex value; anything unrecognised is flagged invalid.
  always_comb begin
    valid  = 1'b1;
    blank  = 1'b0;
    nibble = 4'h0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        valid = 1'b0;
        blank = 1'b1;
      end
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/tt_um_mikegoelzer_7segreader.sv
// Seven-segment display reader: watches a multiplexed two-digit display,
// debounces each glyph, and assembles high/low hex digits into bytes.
//   ui_in[6:0]  segments g..a       ui_in[7]  digit select (0 = low, 1 = high)
//   uio_in[0]   error clear (level) uio_in[1] segments are active-low
//   uo_out      last assembled byte
//   uio_out     [7] byte_valid pulse, [6] sticky error, [5:4] byte count, [3:0] 0
//   uio_oe      upper nibble of uio driven as outputs
module tt_um_mikegoelzer_7segreader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_PRE = 8'(STABLE_CYCLES - 1);

  logic [7:0] ui_meta_r;
  logic [7:0] ui_sync_r;
  logic [1:0] ctl_meta_r;
  logic [1:0] ctl_sync_r;
  logic [7:0] prev_r;
  logic [7:0] stab_cnt_r;
  rd_state_t  state_r;
  rd_state_t  state_s;
  logic [3:0] lo_r;
  logic [3:0] hi_r;
  logic [3:0] lo_s;
  logic [3:0] hi_s;
  logic [7:0] uo_r;
  logic       byte_valid_r;
  logic       err_r;
  logic [1:0] count_r;

  logic [7:0] sample_s;
  logic       same_s;
  logic       accept_s;
  logic       complete_s;
  logic       err_set_s;
  logic       dec_valid_s;
  logic       dec_blank_s;
  logic [3:0] dec_nibble_s;
  logic       unused_s;

  assign unused_s = &{1'b0, ena, uio_in[7:2]};

  // Normalise polarity so the decoder always sees active-high segments.
  assign sample_s = {ui_sync_r[7], ui_sync_r[6:0] ^ {7{ctl_sync_r[1]}}};
  assign same_s   = (sample_s == prev_r);
  // Fires once per stable period: only on the step from MAX-1 to MAX.
  assign accept_s = same_s && (stab_cnt_r == STABLE_PRE);

  seg7_decode u_decode (
    .pattern (sample_s[6:0]),
    .valid   (dec_valid_s),
    .blank   (dec_blank_s),
    .nibble  (dec_nibble_s)
  );

  // Two-flop synchronizers for all asynchronous inputs that are used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_meta_r  <= 8'h00;
      ui_sync_r  <= 8'h00;
      ctl_meta_r <= 2'b00;
      ctl_sync_r <= 2'b00;
    end else begin
      ui_meta_r  <= ui_in;
      ui_sync_r  <= ui_meta_r;
      ctl_meta_r <= uio_in[1:0];
      ctl_sync_r <= ctl_meta_r;
    end
  end

  // Stability counter: restarts on any change, saturates once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r     <= 8'h00;
      stab_cnt_r <= 8'h00;
    end else begin
      prev_r <= sample_s;
      if (!same_s) begin
        stab_cnt_r <= 8'h00;
      end else if (stab_cnt_r != STABLE_MAX) begin
        stab_cnt_r <= stab_cnt_r + 8'h01;
      end else begin
        stab_cnt_r <= stab_cnt_r;
      end
    end
  end

  // FSM state and nibble registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      lo_r    <= 4'h0;
      hi_r    <= 4'h0;
    end else begin
      state_r <= state_s;
      lo_r    <= lo_s;
      hi_r    <= hi_s;
    end
  end

  // Next-state logic: capture nibbles on accepted glyphs, complete on the opposite digit.
  always_comb begin
    state_s    = state_r;
    lo_s       = lo_r;
    hi_s       = hi_r;
    complete_s = 1'b0;
    err_set_s  = 1'b0;
    if (accept_s) begin
      if (dec_valid_s) begin
        if (!sample_s[7]) begin
          lo_s = dec_nibble_s;
          case (state_r)
            ST_EMPTY:  state_s = ST_GOT_LO;
            ST_GOT_LO: state_s = ST_GOT_LO;
            ST_GOT_HI: begin
              state_s    = ST_EMPTY;
              complete_s = 1'b1;
            end
            default:   state_s = ST_EMPTY;
          endcase
        end else begin
          hi_s = dec_nibble_s;
          case (state_r)
            ST_EMPTY:  state_s = ST_GOT_HI;
            ST_GOT_HI: state_s = ST_GOT_HI;
            ST_GOT_LO: begin
              state_s    = ST_EMPTY;
              complete_s = 1'b1;
            end
            default:   state_s = ST_EMPTY;
          endcase
        end
      end else if (dec_blank_s) begin
        err_set_s = 1'b0;
      end else begin
        // Unrecognised glyph: flag it but leave assembly untouched.
        err_set_s = 1'b1;
      end
    end else begin
      state_s = state_r;
    end
  end

  // Output registers: byte, one-cycle valid pulse, sticky error, byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_r         <= 8'h00;
      byte_valid_r <= 1'b0;
      err_r        <= 1'b0;
      count_r      <= 2'b00;
    end else begin
      byte_valid_r <= complete_s;
      if (complete_s) begin
        uo_r    <= {hi_s, lo_s};
        count_r <= count_r + 2'b01;
      end else begin
        uo_r    <= uo_r;
        count_r <= count_r;
      end
      // Set takes priority over a concurrent clear.
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (ctl_sync_r[0]) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign uo_out  = uo_r;
  assign uio_out = {byte_valid_r, err_r, count_r, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_mikegoelzer_7segreader.sv
module tb_tt_um_mikegoelzer_7segreader;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_mikegoelzer_7segreader #(.STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] uio;
    int         at_edge;
  } exp_t;
  exp_t sb_q[$];

  // Hex glyph table (a = bit0), index = hex value.
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state.
  bit         have_lo, have_hi, m_err;
  logic [3:0] m_lo, m_hi;
  int         m_count;
  logic [7:0] run_key;
  int         run_len, run_start;
  bit         last_dsel, last_inv;
  logic [6:0] last_pat;
  logic [7:0] mon_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // A glyph that has been held long enough is interpreted here.
  task automatic model_digit(input logic [7:0] key, input int at_edge);
    int n;
    exp_t e;
    n = -1;
    for (int i = 0; i < 16; i++) if (seg_tbl[i] == key[6:0]) n = i;
    if (key[6:0] == 7'h00) return;
    if (n < 0) begin
      m_err = 1'b1;
      return;
    end
    if (key[7] == 1'b0) begin
      m_lo = n[3:0];
      if (have_hi) begin
        m_count = (m_count + 1) % 4;
        e.data = {m_hi, m_lo};
        e.uio = {1'b1, m_err, 2'(m_count), 4'h0};
        e.at_edge = at_edge;
        sb_q.push_back(e);
        have_lo = 1'b0; have_hi = 1'b0;
      end else have_lo = 1'b1;
    end else begin
      m_hi = n[3:0];
      if (have_lo) begin
        m_count = (m_count + 1) % 4;
        e.data = {m_hi, m_lo};
        e.uio = {1'b1, m_err, 2'(m_count), 4'h0};
        e.at_edge = at_edge;
        sb_q.push_back(e);
        have_lo = 1'b0; have_hi = 1'b0;
      end else have_hi = 1'b1;
    end
  endtask

  // Drive a logical glyph for 'hold' clock edges; a run of the same glyph
  // is accepted once it spans S+1 edges, with the result S+2 edges after its start.
  task automatic present(input bit dsel, input logic [6:0] pat, input bit inv, input int hold);
    logic [7:0] key;
    int old_len;
    key = {dsel, pat};
    ui_in = {dsel, inv ? ~pat : pat};
    uio_in[1] = inv;
    last_dsel = dsel; last_pat = pat; last_inv = inv;
    if (key == run_key) begin
      old_len = run_len;
      run_len = run_len + hold;
    end else begin
      old_len = 0;
      run_key = key;
      run_len = hold;
      run_start = cyc + 1;
    end
    if (old_len < S + 1 && run_len >= S + 1) model_digit(key, run_start + S + 2);
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    present(last_dsel, last_pat, last_inv, n);
  endtask

  task automatic do_reset();
    ui_in = 8'h00; uio_in = 8'h00;
    #2;
    rst_n = 1'b0;
    mon_last = 8'h00;
    have_lo = 1'b0; have_hi = 1'b0; m_err = 1'b0; m_count = 0;
    sb_q.delete();
    run_key = 8'h00; run_len = S + 1; run_start = 0;
    last_dsel = 1'b0; last_pat = 7'h00; last_inv = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'hF0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_err(input string name);
    idle(S + 4);
    check(name, uio_out[6], m_err);
  endtask

  function automatic logic [6:0] rand_invalid();
    logic [6:0] p;
    bit ok;
    do begin
      p = 7'($urandom);
      ok = (p != 7'h00);
      for (int i = 0; i < 16; i++) if (seg_tbl[i] == p) ok = 1'b0;
    end while (!ok);
    return p;
  endfunction

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (uio_out[7]) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte_valid actual uo_out=%0h expected no byte (t=%0t)", uo_out, $time);
          end else begin
            e = sb_q.pop_front();
            check("byte_data", uo_out, e.data);
            check("byte_status", uio_out, e.uio);
            check("byte_edge", cyc, e.at_edge);
            mon_last = e.data;
          end
        end else begin
          check("uo_out_hold", uo_out, mon_last);
        end
      end
    end
  endtask

  initial begin
    int hold, r;
    bit dsel, inv;
    logic [6:0] pat;
    fork
      monitor_loop();
    join_none

    do_reset();

    // Basic: '3' high then '7' low.
    present(1'b1, 7'h4F, 1'b0, 10);
    present(1'b0, 7'h07, 1'b0, S + 6);

    // Mid-assembly reset discards the partial nibble.
    present(1'b0, seg_tbl[9], 1'b0, S + 4);
    do_reset();
    present(1'b1, seg_tbl[12], 1'b0, S + 4);
    present(1'b0, seg_tbl[4], 1'b0, S + 4);

    // Glitching high-digit glyphs never get accepted.
    for (int i = 0; i < 10; i++) present(1'b1, (i % 2 == 0) ? seg_tbl[1] : seg_tbl[8], 1'b0, 2);
    present(1'b0, 7'h00, 1'b0, S + 4);
    check_err("glitch_err");
    present(1'b0, seg_tbl[3], 1'b0, S + 4);
    present(1'b1, seg_tbl[2], 1'b0, S + 4);

    // Active-low segments.
    present(1'b0, seg_tbl[10], 1'b1, S + 4);
    present(1'b1, seg_tbl[11], 1'b1, S + 4);

    // Invalid glyph sets sticky error without disturbing assembly.
    present(1'b0, seg_tbl[5], 1'b0, S + 4);
    present(1'b0, 7'h01, 1'b0, S + 4);
    check_err("err_set");
    uio_in[0] = 1'b1;
    idle(3);
    uio_in[0] = 1'b0;
    idle(4);
    m_err = 1'b0;
    check_err("err_clear");
    present(1'b1, seg_tbl[10], 1'b0, S + 4);

    // Overwrite then complete, then enough bytes to wrap the counter.
    present(1'b0, seg_tbl[1], 1'b0, S + 4);
    present(1'b0, seg_tbl[2], 1'b0, S + 4);
    present(1'b1, seg_tbl[15], 1'b0, S + 4);
    for (int i = 0; i < 4; i++) begin
      present(1'b0, seg_tbl[$urandom_range(0, 15)], 1'b0, S + 3);
      present(1'b1, seg_tbl[$urandom_range(0, 15)], 1'b0, S + 3);
    end

    // Randomized mix including boundary hold lengths S and S+1.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) pat = seg_tbl[$urandom_range(0, 15)];
      else if (r < 8) pat = 7'h00;
      else pat = rand_invalid();
      dsel = 1'($urandom);
      inv = 1'($urandom);
      if ($urandom_range(0, 9) < 3) hold = $urandom_range(1, S);
      else hold = $urandom_range(S + 1, S + 8);
      present(dsel, pat, inv, hold);
    end
    present(1'b0, 7'h00, 1'b0, S + 8);
    check_err("final_err");
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
